dom_and_pipe: RTL and testbench

DOM_AND_PIPE -- requirements
Module: dom_and_pipe

---
 rtl/dom_and_pipe.sv | 71 +++++++
 tb/tb_dom_and_pipe.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dom_and_pipe.sv
// dom_and_pipe: two-stage DOM masked AND; define DOM_AND_PIPE_REFRESH_EN to add in_rr ring refresh of the output shares
module dom_and_pipe #(
  parameter int SHARES = 3,
  parameter int WIDTH = 1,
  localparam int NPAIR = SHARES * (SHARES - 1) / 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SHARES*WIDTH-1:0] in_a,
  input  logic [SHARES*WIDTH-1:0] in_b,
  input  logic [NPAIR*WIDTH-1:0]  in_r,
`ifdef DOM_AND_PIPE_REFRESH_EN
  input  logic [SHARES*WIDTH-1:0] in_rr,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SHARES*WIDTH-1:0] out_c
);
  logic v1, v2, adv1, adv2;
  logic [SHARES*SHARES*WIDTH-1:0] p_nx, p;
  logic [SHARES*WIDTH-1:0] c_nx;
  assign in_ready = !v1 || !v2 || out_ready;
  assign adv1 = in_valid && in_ready;
  assign adv2 = v1 && (!v2 || out_ready);
  assign out_valid = v2;
  for (genvar i = 0; i < SHARES; i++) begin : g_row
    for (genvar j = 0; j < SHARES; j++) begin : g_col
      if (i == j) begin : g_inner
        assign p_nx[(i*SHARES+j)*WIDTH +: WIDTH] = in_a[i*WIDTH +: WIDTH] & in_b[j*WIDTH +: WIDTH];
      end else begin : g_cross
        localparam int LO = (i < j) ? i : j;
        localparam int HI = (i < j) ? j : i;
        localparam int K = LO * SHARES - LO * (LO + 1) / 2 + HI - LO - 1;
        assign p_nx[(i*SHARES+j)*WIDTH +: WIDTH] =
          (in_a[i*WIDTH +: WIDTH] & in_b[j*WIDTH +: WIDTH]) ^ in_r[K*WIDTH +: WIDTH];
      end
    end
  end
`ifdef DOM_AND_PIPE_REFRESH_EN
  logic [SHARES*WIDTH-1:0] rr;
  always_ff @(posedge clk) begin
    if (rst) rr <= '0;
    else if (adv1) rr <= in_rr;
  end
`endif
  always_comb begin
    c_nx = '0;
    for (int i = 0; i < SHARES; i++)
      for (int j = 0; j < SHARES; j++)
        c_nx[i*WIDTH +: WIDTH] = c_nx[i*WIDTH +: WIDTH] ^ p[(i*SHARES+j)*WIDTH +: WIDTH];
`ifdef DOM_AND_PIPE_REFRESH_EN
    for (int i = 0; i < SHARES; i++)
      c_nx[i*WIDTH +: WIDTH] = c_nx[i*WIDTH +: WIDTH] ^ rr[i*WIDTH +: WIDTH] ^ rr[((i+1)%SHARES)*WIDTH +: WIDTH];
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      p <= '0;
      out_c <= '0;
    end else begin
      if (adv1) p <= p_nx;
      if (adv2) out_c <= c_nx;
      v1 <= adv1 || (v1 && !adv2);
      v2 <= adv2 || (v2 && !out_ready);
    end
  end
endmodule

// File: tb/tb_dom_and_pipe.sv
// tb_dom_and_pipe: directed checks of dom_and_pipe at SHARES=3 and SHARES=2, WIDTH=1
module tb_dom_and_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic iv3, ir3, ov3, or3;
  logic [2:0] a3, b3, r3, c3;
  logic iv2, ir2, ov2, or2;
  logic [1:0] a2, b2, c2;
  logic [0:0] r2;
`ifdef DOM_AND_PIPE_REFRESH_EN
  logic [2:0] rr3;
  logic [1:0] rr2;
  localparam logic [2:0] E1 = 3'b010;
  localparam logic [2:0] E2 = 3'b001;
`else
  localparam logic [2:0] E1 = 3'b100;
  localparam logic [2:0] E2 = 3'b111;
`endif
  int errors = 0;
  int checks = 0;

  dom_and_pipe #(.SHARES(3), .WIDTH(1)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3),
    .in_a(a3), .in_b(b3), .in_r(r3),
`ifdef DOM_AND_PIPE_REFRESH_EN
    .in_rr(rr3),
`endif
    .out_valid(ov3), .out_ready(or3), .out_c(c3)
  );

  dom_and_pipe #(.SHARES(2), .WIDTH(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
    .in_a(a2), .in_b(b2), .in_r(r2),
`ifdef DOM_AND_PIPE_REFRESH_EN
    .in_rr(rr2),
`endif
    .out_valid(ov2), .out_ready(or2), .out_c(c2)
  );

  task automatic test_reset();
    int stale = 0;
    rst = 1'b1; or3 = 1'b1; or2 = 1'b1;
    iv3 = 1'b1; a3 = 3'b111; b3 = 3'b111; r3 = 3'b000;
    iv2 = 1'b1; a2 = 2'b11; b2 = 2'b11; r2 = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL reset_out_valid3 got=%b exp=0", ov3); end
    checks++; if (ir3 !== 1'b1) begin errors++; $display("FAIL reset_in_ready3 got=%b exp=1", ir3); end
    checks++; if (c3 !== 3'b000) begin errors++; $display("FAIL reset_out_c3 got=%b exp=000", c3); end
    checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL reset_out_valid2 got=%b exp=0", ov2); end
    checks++; if (c2 !== 2'b00) begin errors++; $display("FAIL reset_out_c2 got=%b exp=00", c2); end
    rst = 1'b0; iv3 = 1'b0; iv2 = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ov3 || ov2) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL reset_cycle_input_accepted got=%0d exp=0", stale); end
  endtask

  task automatic test_basic();
    @(negedge clk);
    iv3 = 1'b1; a3 = 3'b001; b3 = 3'b010; r3 = 3'b101; or3 = 1'b1;
    @(negedge clk);
    iv3 = 1'b0; a3 = 3'b111; r3 = 3'b010;
    checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", ov3); end
    @(negedge clk);
    checks++; if (ov3 !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", ov3); end
    checks++; if (c3 !== E1) begin errors++; $display("FAIL basic_out_c got=%b exp=%b", c3, E1); end
    checks++; if ((^c3) !== 1'b1) begin errors++; $display("FAIL basic_xor got=%b exp=1", ^c3); end
    @(negedge clk);
    checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL basic_duplicate got=%b exp=0", ov3); end
  endtask

  task automatic test_exhaustive();
    logic [2:0] exp_q[$];
    logic [2:0] e;
    logic [1:0] ec;
    int got = 0;
    int acc = 0;
    or2 = 1'b1;
    for (int n = 0; n < 72; n++) begin
      @(negedge clk);
      if (ov2) begin
        got++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
        checks++; if (c2 !== e[1:0]) begin errors++; $display("FAIL exh_out_c idx=%0d got=%b exp=%b", got - 1, c2, e[1:0]); end
        checks++; if ((^c2) !== e[2]) begin errors++; $display("FAIL exh_xor idx=%0d got=%b exp=%b", got - 1, ^c2, e[2]); end
      end
      iv2 = (n < 64);
      a2 = n[1:0]; b2 = n[3:2]; r2 = n[4];
`ifdef DOM_AND_PIPE_REFRESH_EN
      rr2 = 2'b00;
`endif
      #1;
      if (iv2 && ir2) begin
        acc++;
        ec[0] = (a2[0] & b2[0]) ^ (a2[0] & b2[1]) ^ r2[0];
        ec[1] = (a2[1] & b2[1]) ^ (a2[1] & b2[0]) ^ r2[0];
        exp_q.push_back({(^a2) & (^b2), ec});
      end
    end
    checks++; if (acc !== 64) begin errors++; $display("FAIL exh_accepts got=%0d exp=64", acc); end
    checks++; if (got !== 64) begin errors++; $display("FAIL exh_outputs got=%0d exp=64", got); end
  endtask

  task automatic test_stall();
    logic [2:0] va[3] = '{3'b001, 3'b111, 3'b010};
    logic [2:0] vb[3] = '{3'b010, 3'b111, 3'b010};
    logic [2:0] vr[3] = '{3'b101, 3'b000, 3'b111};
    logic [2:0] got[$];
    int acc = 0;
    @(negedge clk);
    or3 = 1'b0; iv3 = 1'b0;
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      if (n >= 2) begin
        checks++; if (ov3 !== 1'b1 || c3 !== E1) begin errors++; $display("FAIL stall_hold cyc=%0d got=%b/%b exp=1/%b", n, ov3, c3, E1); end
      end
      iv3 = 1'b1; a3 = va[acc]; b3 = vb[acc]; r3 = vr[acc];
      #1;
      if (ir3) acc++;
    end
    checks++; if (acc !== 2) begin errors++; $display("FAIL stall_accepts got=%0d exp=2", acc); end
    checks++; if (ir3 !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b exp=0", ir3); end
    @(negedge clk);
    iv3 = 1'b0; or3 = 1'b1;
    #1;
    for (int n = 0; n < 6; n++) begin
      if (ov3) got.push_back(c3);
      @(negedge clk);
      #1;
    end
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL stall_count got=%0d exp=2", got.size()); end
    if (got.size() >= 2) begin
      checks++; if (got[0] !== E1) begin errors++; $display("FAIL stall_first got=%b exp=%b", got[0], E1); end
      checks++; if (got[1] !== E2) begin errors++; $display("FAIL stall_second got=%b exp=%b", got[1], E2); end
    end
  endtask

  task automatic test_reset_flight();
    int stale = 0;
    @(negedge clk);
    or3 = 1'b0; iv3 = 1'b1; a3 = 3'b001; b3 = 3'b010; r3 = 3'b101;
    @(negedge clk);
    a3 = 3'b111; b3 = 3'b111; r3 = 3'b000;
    @(negedge clk);
    checks++; if (ov3 !== 1'b1) begin errors++; $display("FAIL flight_full got=%b exp=1", ov3); end
    rst = 1'b1; a3 = 3'b011; b3 = 3'b011; r3 = 3'b110;
    @(negedge clk);
    rst = 1'b0; iv3 = 1'b0; or3 = 1'b1;
    #1;
    checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL flight_out_valid got=%b exp=0", ov3); end
    checks++; if (c3 !== 3'b000) begin errors++; $display("FAIL flight_out_c got=%b exp=000", c3); end
    checks++; if (ir3 !== 1'b1) begin errors++; $display("FAIL flight_in_ready got=%b exp=1", ir3); end
    repeat (6) begin
      @(negedge clk);
      if (ov3) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL flight_stale got=%0d exp=0", stale); end
  endtask

  initial begin
`ifdef DOM_AND_PIPE_REFRESH_EN
    rr3 = 3'b011;
    rr2 = 2'b00;
`endif
    test_reset();
    test_basic();
    test_exhaustive();
    test_stall();
    test_reset_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
